// File: rtl/packet_status_table.sv
// ============================================================================
// Module   : packet_status_table
// Purpose  : Per-tag verdict store between the forwarder, the filter cores and
//            the reorder circular buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module packet_status_table #(
  parameter int TAG_WIDTH = 6,
  parameter int NUM_TAGS  = 50,
  parameter int NUM_CORES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alloc_valid,
  input  logic [TAG_WIDTH-1:0]           alloc_tag,
  output logic                           alloc_ready,
  input  logic [NUM_CORES-1:0]           verdict_valid,
  input  logic [NUM_CORES*TAG_WIDTH-1:0] verdict_tag,
  input  logic [NUM_CORES-1:0]           verdict_accept,
  output logic [NUM_CORES-1:0]           verdict_ready,
  input  logic [TAG_WIDTH-1:0]           lookup_tag,
  output logic [1:0]                     packet_status,
  output logic [TAG_WIDTH:0]             pending_count,
  output logic                           err_alloc,
  output logic                           err_verdict
);

  localparam int         c_PTR_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [1:0] c_FREE    = 2'b00;
  localparam logic [1:0] c_PENDING = 2'b10;

  logic [1:0]           r_entry [NUM_TAGS];
  logic [c_PTR_W-1:0]   r_rr_ptr;
  logic [TAG_WIDTH-1:0] r_prev_tag;
  logic [TAG_WIDTH:0]   r_pending_count;
  logic                 r_err_alloc;
  logic                 r_err_verdict;

  logic                 w_grant_any;
  logic [c_PTR_W-1:0]   w_grant_idx;
  int                   w_idx;
  logic [TAG_WIDTH-1:0] w_vtag;
  logic                 w_vaccept;
  logic                 w_verdict_ok;
  logic                 w_alloc_fire;
  logic                 w_retire;

  function automatic logic in_range(input logic [TAG_WIDTH-1:0] t);
    return int'(t) < NUM_TAGS;
  endfunction

  assign alloc_ready   = in_range(alloc_tag) && (r_entry[alloc_tag] == c_FREE);
  assign w_alloc_fire  = alloc_valid && alloc_ready;
  assign packet_status = in_range(lookup_tag) ? r_entry[lookup_tag] : c_FREE;

  // Round-robin search starting at r_rr_ptr, wrapping past the last core.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_idx       = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_idx = (int'(r_rr_ptr) + i) % NUM_CORES;
      if (!w_grant_any && verdict_valid[w_idx]) begin
        w_grant_any = 1'b1;
        w_grant_idx = c_PTR_W'(w_idx);
      end
    end
  end

  assign verdict_ready = w_grant_any ? (NUM_CORES'(1) << w_grant_idx) : '0;
  assign w_vtag        = verdict_tag[int'(w_grant_idx)*TAG_WIDTH +: TAG_WIDTH];
  assign w_vaccept     = verdict_accept[w_grant_idx];
  assign w_verdict_ok  = in_range(w_vtag) && (r_entry[w_vtag] == c_PENDING);

  // ACCEPT (11) and REJECT (01) are the only states with bit 0 set.
  assign w_retire = (lookup_tag != r_prev_tag) && in_range(r_prev_tag) &&
                    r_entry[r_prev_tag][0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        r_entry[t] <= c_FREE;
      end
      r_rr_ptr        <= '0;
      r_prev_tag      <= '0;
      r_pending_count <= '0;
      r_err_alloc     <= 1'b0;
      r_err_verdict   <= 1'b0;
    end else begin
      r_prev_tag <= lookup_tag;

      if (w_alloc_fire) begin
        r_entry[alloc_tag] <= c_PENDING;
      end else if (alloc_valid) begin
        r_err_alloc <= 1'b1;
      end

      if (w_grant_any) begin
        r_rr_ptr <= (int'(w_grant_idx) == NUM_CORES - 1) ? '0 : w_grant_idx + 1'b1;
        if (w_verdict_ok) begin
          r_entry[w_vtag] <= {w_vaccept, 1'b1};
        end else begin
          r_err_verdict <= 1'b1;
        end
      end

      if (w_retire) begin
        r_entry[r_prev_tag] <= c_FREE;
      end

      if (w_alloc_fire && !w_retire) begin
        r_pending_count <= r_pending_count + 1'b1;
      end else if (!w_alloc_fire && w_retire) begin
        r_pending_count <= r_pending_count - 1'b1;
      end
    end
  end

  assign pending_count = r_pending_count;
  assign err_alloc     = r_err_alloc;
  assign err_verdict   = r_err_verdict;

endmodule

`default_nettype wire

// File: tb/tb_packet_status_table.sv
// ============================================================================
// Module   : tb_packet_status_table
// Purpose  : Directed self-checking bench for packet_status_table.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_packet_status_table;

  localparam int c_TW = 6;
  localparam int c_NC = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   alloc_valid;
  logic [c_TW-1:0]        alloc_tag;
  logic                   alloc_ready;
  logic [c_NC-1:0]        verdict_valid;
  logic [c_NC*c_TW-1:0]   verdict_tag;
  logic [c_NC-1:0]        verdict_accept;
  logic [c_NC-1:0]        verdict_ready;
  logic [c_TW-1:0]        lookup_tag;
  logic [1:0]             packet_status;
  logic [c_TW:0]          pending_count;
  logic                   err_alloc;
  logic                   err_verdict;

  int n_pass  = 0;
  int n_total = 0;

  packet_status_table #(.TAG_WIDTH(6), .NUM_TAGS(50), .NUM_CORES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid    (alloc_valid),
    .alloc_tag      (alloc_tag),
    .alloc_ready    (alloc_ready),
    .verdict_valid  (verdict_valid),
    .verdict_tag    (verdict_tag),
    .verdict_accept (verdict_accept),
    .verdict_ready  (verdict_ready),
    .lookup_tag     (lookup_tag),
    .packet_status  (packet_status),
    .pending_count  (pending_count),
    .err_alloc      (err_alloc),
    .err_verdict    (err_verdict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_core(input int k, input int tag, input logic acc);
    verdict_tag[k*c_TW +: c_TW] = c_TW'(tag);
    verdict_accept[k]           = acc;
  endtask

  task automatic do_alloc(input int tag);
    alloc_valid = 1'b1;
    alloc_tag   = c_TW'(tag);
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst            = 1'b0;
    alloc_valid    = 1'b0;
    alloc_tag      = '0;
    verdict_valid  = '0;
    verdict_tag    = '0;
    verdict_accept = '0;
    lookup_tag     = '0;
    tick();
    tick();
    rst = 1'b1;

    // Reset state
    alloc_tag = 6'd5;
    settle();
    check("rst_status", 32'(packet_status), 32'd0);
    check("rst_pending", 32'(pending_count), 32'd0);
    check("rst_err_alloc", 32'(err_alloc), 32'd0);
    check("rst_err_verdict", 32'(err_verdict), 32'd0);
    check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check("rst_vready", 32'(verdict_ready), 32'd0);

    // Allocate and accept tag 5 through core 2
    do_alloc(5);
    lookup_tag = 6'd5;
    settle();
    check("alloc5_status", 32'(packet_status), 32'b10);
    check("alloc5_pending", 32'(pending_count), 32'd1);
    set_core(2, 5, 1'b1);
    verdict_valid = 4'b0100;
    settle();
    check("acc5_ready", 32'(verdict_ready), 32'b0100);
    tick();
    verdict_valid = '0;
    settle();
    check("acc5_status", 32'(packet_status), 32'b11);
    check("acc5_pending", 32'(pending_count), 32'd1);

    // Round-robin from rr_ptr = 0
    do_reset();
    lookup_tag = 6'd40;
    for (int t = 0; t < 5; t++) do_alloc(t);
    check("rr_pending0", 32'(pending_count), 32'd5);
    for (int k = 0; k < 4; k++) set_core(k, k, (k % 2) == 0);
    verdict_valid = 4'b1111;
    settle();
    check("rr_grant0", 32'(verdict_ready), 32'b0001);
    tick();
    set_core(0, 4, 1'b1);
    settle();
    check("rr_grant1", 32'(verdict_ready), 32'b0010);
    tick();
    check("rr_grant2", 32'(verdict_ready), 32'b0100);
    tick();
    check("rr_grant3", 32'(verdict_ready), 32'b1000);
    tick();
    check("rr_grant4", 32'(verdict_ready), 32'b0001);
    tick();
    verdict_valid = '0;
    settle();
    check("rr_err_verdict", 32'(err_verdict), 32'd0);
    check("rr_pending1", 32'(pending_count), 32'd5);
    // Walk the written tags; each step retires the one before
    for (int t = 0; t < 5; t++) begin
      lookup_tag = c_TW'(t);
      settle();
      check($sformatf("rr_status%0d", t), 32'(packet_status), (t % 2 == 0) ? 32'b11 : 32'b01);
      tick();
    end
    lookup_tag = 6'd40;
    tick();
    check("rr_retired_pending", 32'(pending_count), 32'd0);
    alloc_tag = 6'd0;
    settle();
    check("rr_tag0_free", 32'(alloc_ready), 32'd1);

    // Retire with wrap 48 -> 49 -> 0 (rr_ptr is 1 here)
    do_alloc(48);
    do_alloc(49);
    set_core(1, 48, 1'b1);
    verdict_valid = 4'b0010;
    settle();
    check("wrap_ready1", 32'(verdict_ready), 32'b0010);
    tick();
    set_core(3, 49, 1'b1);
    verdict_valid = 4'b1000;
    settle();
    check("wrap_ready3", 32'(verdict_ready), 32'b1000);
    tick();
    verdict_valid = '0;
    lookup_tag = 6'd48;
    settle();
    check("wrap_pending2", 32'(pending_count), 32'd2);
    check("wrap_st48", 32'(packet_status), 32'b11);
    tick();
    lookup_tag = 6'd49;
    settle();
    check("wrap_st49", 32'(packet_status), 32'b11);
    tick();
    alloc_tag = 6'd48;
    settle();
    check("wrap_48_free", 32'(alloc_ready), 32'd1);
    check("wrap_pending1", 32'(pending_count), 32'd1);
    lookup_tag = 6'd0;
    tick();
    alloc_tag = 6'd49;
    settle();
    check("wrap_49_free", 32'(alloc_ready), 32'd1);
    check("wrap_pending0", 32'(pending_count), 32'd0);

    // Errors (rr_ptr is 0 here)
    do_alloc(7);
    alloc_tag = 6'd7;
    settle();
    check("err_ready7", 32'(alloc_ready), 32'd0);
    do_alloc(7);
    settle();
    check("err_alloc_set", 32'(err_alloc), 32'd1);
    lookup_tag = 6'd7;
    settle();
    check("err_st7", 32'(packet_status), 32'b10);
    set_core(0, 9, 1'b1);
    verdict_valid = 4'b0001;
    settle();
    check("err_vready", 32'(verdict_ready), 32'b0001);
    tick();
    verdict_valid = '0;
    lookup_tag = 6'd9;
    settle();
    check("err_verdict_set", 32'(err_verdict), 32'd1);
    check("err_st9", 32'(packet_status), 32'b00);
    check("err_pending", 32'(pending_count), 32'd1);
    alloc_tag = 6'd55;
    lookup_tag = 6'd60;
    settle();
    check("oor_alloc_ready", 32'(alloc_ready), 32'd0);
    check("oor_status", 32'(packet_status), 32'd0);
    tick();
    tick();
    check("err_alloc_sticky", 32'(err_alloc), 32'd1);
    check("err_verdict_sticky", 32'(err_verdict), 32'd1);
    do_reset();
    settle();
    check("err_alloc_clr", 32'(err_alloc), 32'd0);
    check("err_verdict_clr", 32'(err_verdict), 32'd0);

    // Simultaneous alloc + retire + verdict
    lookup_tag = 6'd0;
    do_alloc(3);
    do_alloc(4);
    set_core(0, 3, 1'b0);
    verdict_valid = 4'b0001;
    tick();
    verdict_valid = '0;
    lookup_tag = 6'd3;
    tick();
    check("sim_st3", 32'(packet_status), 32'b01);
    check("sim_pending_pre", 32'(pending_count), 32'd2);
    lookup_tag    = 6'd11;
    alloc_valid   = 1'b1;
    alloc_tag     = 6'd10;
    set_core(0, 4, 1'b1);
    verdict_valid = 4'b0001;
    settle();
    check("sim_alloc_ready", 32'(alloc_ready), 32'd1);
    check("sim_vready", 32'(verdict_ready), 32'b0001);
    tick();
    alloc_valid   = 1'b0;
    verdict_valid = '0;
    alloc_tag     = 6'd3;
    settle();
    check("sim_pending_post", 32'(pending_count), 32'd2);
    check("sim_3_free", 32'(alloc_ready), 32'd1);
    lookup_tag = 6'd4;
    settle();
    check("sim_st4", 32'(packet_status), 32'b11);
    lookup_tag = 6'd10;
    settle();
    check("sim_st10", 32'(packet_status), 32'b10);
    check("sim_errs", 32'({err_alloc, err_verdict}), 32'd0);

    // Reset mid-operation
    do_reset();
    lookup_tag = 6'd0;
    for (int t = 20; t < 40; t++) do_alloc(t);
    check("mid_pending20", 32'(pending_count), 32'd20);
    set_core(1, 20, 1'b1);
    set_core(3, 21, 1'b1);
    verdict_valid = 4'b0010;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    verdict_valid = 4'b1010;
    lookup_tag = 6'd20;
    settle();
    check("mid_pending0", 32'(pending_count), 32'd0);
    check("mid_st20", 32'(packet_status), 32'b00);
    check("mid_regrant", 32'(verdict_ready), 32'b0010);
    lookup_tag = 6'd39;
    settle();
    check("mid_st39", 32'(packet_status), 32'b00);
    verdict_valid = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/packet_status_table.md
# packet_status_table

Per-tag verdict store between the forwarder, the filter cores and the reorder circular buffer. The forwarder registers each reorder tag when it dispatches a packet. Filter cores post accept/reject verdicts through a round-robin arbiter, one per cycle. The circular buffer presents its current output tag and reads that tag's status combinationally. An entry is retired back to free once the buffer moves past its tag.

## Interface
- TAG_WIDTH, 6, reorder tag width
- NUM_TAGS, 50, number of table entries; valid tags are 0..NUM_TAGS-1
- NUM_CORES, 4, number of filter cores posting verdicts

- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (rst=0 resets on the rising edge of clk)
- alloc_valid  in  1  forwarder registers alloc_tag as in flight
- alloc_tag  in  TAG_WIDTH  tag being dispatched
- alloc_ready  out  1  alloc_tag is in range and its entry is FREE
- verdict_valid  in  NUM_CORES  per-core verdict request
- verdict_tag  in  NUM_CORES*TAG_WIDTH  core k's tag in bits [k*TAG_WIDTH +: TAG_WIDTH]
- verdict_accept  in  NUM_CORES  1 = accept, 0 = reject
- verdict_ready  out  NUM_CORES  one-hot grant; at most one bit set
- lookup_tag  in  TAG_WIDTH  current output tag from the circular buffer
- packet_status  out  2  status of entry[lookup_tag]
- pending_count  out  TAG_WIDTH+1  number of non-FREE entries
- err_alloc  out  1  sticky: allocation to a non-FREE or out-of-range tag
- err_verdict  out  1  sticky: verdict to a non-PENDING or out-of-range tag

## Operation
- **Entry encoding (2 bits):**
  - FREE = 00
  - REJECT = 01
  - PENDING = 10
  - ACCEPT = 11
  - The buffer forwards on 11, skips on 01, and waits on anything else.
- **Allocate:**
  - An allocation takes effect when alloc_valid and alloc_ready are both high: the entry goes FREE to PENDING and pending_count increments.
  - alloc_valid with alloc_ready low sets err_alloc. The entry is not modified.
- **Verdict arbiter:**
  - A round-robin pointer rr_ptr (0..NUM_CORES-1) selects the grant.
  - The grant goes to the first core with verdict_valid set, searching from rr_ptr upward and wrapping.
  - verdict_ready is combinational from verdict_valid and rr_ptr.
  - On a grant to core g, rr_ptr becomes (g+1) mod NUM_CORES. With no grant, rr_ptr holds.
  - A core holds verdict_valid, verdict_tag and verdict_accept stable until it sees verdict_ready.
- **Verdict write:**
  - If the granted tag is in range and PENDING, the entry becomes ACCEPT or REJECT according to verdict_accept.
  - Otherwise err_verdict is set and the entry is unchanged. The grant is still consumed.
- **Lookup:** packet_status = entry[lookup_tag] combinationally. An out-of-range lookup_tag returns 00.
- **Retire:**
  - prev_tag registers lookup_tag every cycle.
  - When lookup_tag != prev_tag and entry[prev_tag] is ACCEPT or REJECT, that entry becomes FREE and pending_count decrements.
  - Tag wrap (NUM_TAGS-1 to 0) is an ordinary change and retires normally.
- **Same-cycle events:**
  - All three operations are evaluated against the pre-edge table contents, so they touch distinct entries in legal traffic.
  - An allocation that hits a tag retiring in the same cycle is refused, because the pre-edge state is not FREE.
  - pending_count: alloc plus retire in one cycle leaves it unchanged.
- **Reset mid-operation:**
  - All entries return to FREE and in-flight grants are dropped.
  - Cores must re-present their verdicts after reset releases.

## Timing
- Reset values:
  - All entries FREE, rr_ptr = 0, prev_tag = 0
  - pending_count = 0, err_alloc = 0, err_verdict = 0
  - packet_status = 00, alloc_ready = 1 for any in-range alloc_tag
  - verdict_ready = the combinational grant (0 when no core is valid)
- Allocation is visible in packet_status (10) on the cycle after the accepted edge.
- A verdict is visible in packet_status one cycle after the verdict_valid and verdict_ready edge.
- Lookup has zero latency; packet_status follows lookup_tag in the same cycle.
- Retire: the entry reads FREE on the cycle after lookup_tag changes.
- Throughput: one allocation, one verdict and one retire per cycle.
- Error flags are set at the clock edge of the offending event and clear only on reset.

## Test plan
- **Allocate and accept:** alloc tag 5, then core 2 posts tag 5 accept -> packet_status = 10 one cycle after alloc and 11 one cycle after the grant; pending_count = 1.
- **Round-robin:** all 4 cores valid continuously with distinct PENDING tags, rr_ptr = 0 -> grants go to 0, 1, 2, 3, 0 on consecutive cycles, verdict_ready is one-hot every cycle, and tags 0-3 are written in that order.
- **Retire and wrap:**
  - Setup: tags 48 and 49 are ACCEPT.
  - Stimulus: lookup_tag steps 48 -> 49 -> 0.
  - Response: entry 48 is FREE after the first change and entry 49 after the wrap; pending_count drops by 2.
- **Errors:** alloc to a PENDING tag 7, then a verdict to FREE tag 9 -> err_alloc = 1 and err_verdict = 1; entries 7 and 9 are unchanged; both flags persist until rst = 0.
- **Simultaneous events:**
  - Setup: tag 3 is REJECT and being retired; core 0 holds a verdict for PENDING tag 4.
  - Stimulus: in the same cycle, alloc tag 10 (FREE), retire tag 3, and grant core 0's verdict.
  - Response: entries become 3 = 00, 4 = 11 and 10 = 10; pending_count is unchanged.
- **Reset mid-operation:**
  - Setup: 20 entries are PENDING and core 1 holds verdict_valid.
  - Stimulus: drive rst = 0 for one cycle.
  - Response: all entries are FREE, pending_count = 0, rr_ptr = 0, and core 1 is granted again after release.
